// File: rtl/cc_miss_handler.sv
// cc_miss_handler: serves cache hits from the read line and refills missed lines over a burst memory read.
module cc_miss_handler #(
    parameter int LINE_BEATS = 8,
    parameter int MEM_ADDR_W = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  hit_i,
    input  logic                  miss_i,
    input  logic [16:0]           tag_i,
    input  logic [8:0]            index_i,
    input  logic [5:0]            offset_i,
    input  logic [511:0]          rdata_data_i,
    output logic                  busy_o,
    output logic                  mem_arvalid_o,
    input  logic                  mem_arready_i,
    output logic [MEM_ADDR_W-1:0] mem_araddr_o,
    output logic [3:0]            mem_arlen_o,
    input  logic                  mem_rvalid_i,
    output logic                  mem_rready_o,
    input  logic [63:0]           mem_rdata_i,
    input  logic                  mem_rlast_i,
    output logic                  wren_o,
    output logic [8:0]            waddr_o,
    output logic [17:0]           wdata_tag_o,
    output logic [511:0]          wdata_data_o,
    output logic                  out_rvalid_o,
    input  logic                  out_rready_i,
    output logic [63:0]           out_rdata_o
);
    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_HIT_RESP  = 3'd1;
    localparam logic [2:0] S_MISS_AR   = 3'd2;
    localparam logic [2:0] S_MISS_R    = 3'd3;
    localparam logic [2:0] S_FILL      = 3'd4;
    localparam logic [2:0] S_MISS_RESP = 3'd5;

    logic [2:0]   state_q, state_d;
    logic [2:0]   beat_q, beat_d;
    logic [16:0]  tag_q, tag_d;
    logic [8:0]   index_q, index_d;
    logic [2:0]   word_sel_q, word_sel_d;
    logic [63:0]  word_q, word_d;
    logic [511:0] line_q, line_d;

    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        tag_d      = tag_q;
        index_d    = index_q;
        word_sel_d = word_sel_q;
        word_d     = word_q;
        line_d     = line_q;
        case (state_q)
            S_IDLE: begin
                if (miss_i) begin
                    tag_d      = tag_i;
                    index_d    = index_i;
                    word_sel_d = offset_i[5:3];
                    beat_d     = 3'd0;
                    state_d    = S_MISS_AR;
                end else if (hit_i) begin
                    word_d     = rdata_data_i[{offset_i[5:3], 6'b0} +: 64];
                    word_sel_d = offset_i[5:3];
                    state_d    = S_HIT_RESP;
                end
            end
            S_MISS_AR: state_d = mem_arready_i ? S_MISS_R : S_MISS_AR;
            S_MISS_R: begin
                if (mem_rvalid_i) begin
                    line_d[{beat_q, 6'b0} +: 64] = mem_rdata_i;
                    beat_d  = beat_q + 3'd1;
                    state_d = mem_rlast_i ? S_FILL : S_MISS_R;
                end
            end
            S_FILL: state_d = S_MISS_RESP;
            S_HIT_RESP, S_MISS_RESP: state_d = out_rready_i ? S_IDLE : state_q;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            beat_q     <= '0;
            tag_q      <= '0;
            index_q    <= '0;
            word_sel_q <= '0;
            word_q     <= '0;
            line_q     <= '0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            tag_q      <= tag_d;
            index_q    <= index_d;
            word_sel_q <= word_sel_d;
            word_q     <= word_d;
            line_q     <= line_d;
        end
    end

    // Every output is decoded from state, so reset clears them without a clock edge.
    assign busy_o        = state_q != S_IDLE;
    assign mem_arvalid_o = state_q == S_MISS_AR;
    assign mem_araddr_o  = mem_arvalid_o ? MEM_ADDR_W'({tag_q, index_q, 6'b0}) : '0;
    assign mem_arlen_o   = mem_arvalid_o ? 4'(LINE_BEATS - 1) : '0;
    assign mem_rready_o  = state_q == S_MISS_R;
    assign wren_o        = state_q == S_FILL;
    assign waddr_o       = wren_o ? index_q : '0;
    assign wdata_tag_o   = wren_o ? {1'b1, tag_q} : '0;
    assign wdata_data_o  = wren_o ? line_q : '0;
    assign out_rvalid_o  = (state_q == S_HIT_RESP) || (state_q == S_MISS_RESP);
    assign out_rdata_o   = (state_q == S_HIT_RESP)  ? word_q :
                           (state_q == S_MISS_RESP) ? line_q[{word_sel_q, 6'b0} +: 64] : '0;
endmodule
